pio_led_ctrl: RTL

PIO_LED_CTRL -- requirements
Module: pio_led_ctrl

---
 rtl/pio_led_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pio_led_ctrl.sv
// pio_led_ctrl: memory-mapped LED port with per-bit blink and global PWM dimming.
// Optional PWM stage is built only when PIO_LED_CTRL_PWM_EN is defined; otherwise
// pwm_on is tied high and address 5 reads 0 and ignores writes.
module pio_led_ctrl #(
    parameter int unsigned WIDTH         = 26,
    parameter int unsigned PRESCALE_BITS = 24,
    parameter int unsigned PWM_BITS      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_MODE   = 3'd3;
    localparam logic [2:0] ADDR_PERIOD = 3'd4;
    localparam logic [2:0] ADDR_DUTY   = 3'd5;

    logic                     wr_en;
    logic [WIDTH-1:0]         wr_bits;
    logic [WIDTH-1:0]         data;
    logic [WIDTH-1:0]         mode;
    logic [PRESCALE_BITS-1:0] period;
    logic [PRESCALE_BITS-1:0] prescale;
    logic                     blink_phase;
    logic                     pwm_on;
    logic [WIDTH-1:0]         out_next;
    logic                     unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wr_bits   = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    // DATA register with direct write, write-1-to-set and write-1-to-clear aliases
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:  data <= wr_bits;
                ADDR_SET:   data <= data | wr_bits;
                ADDR_CLEAR: data <= data & ~wr_bits;
                default:    data <= data;
            endcase
        end
    end

    // MODE and PERIOD configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode   <= '0;
            period <= '0;
        end else if (wr_en) begin
            if (address == ADDR_MODE) begin
                mode <= wr_bits;
            end
            if (address == ADDR_PERIOD) begin
                period <= writedata[PRESCALE_BITS-1:0];
            end
        end
    end

    // Blink prescaler: PERIOD write restarts the phase, PERIOD=0 parks it high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale    <= '0;
            blink_phase <= 1'b1;
        end else if (wr_en && (address == ADDR_PERIOD)) begin
            prescale    <= writedata[PRESCALE_BITS-1:0];
            blink_phase <= 1'b1;
        end else if (period == '0) begin
            prescale    <= '0;
            blink_phase <= 1'b1;
        end else if (prescale == '0) begin
            prescale    <= period;
            blink_phase <= ~blink_phase;
        end else begin
            prescale    <= prescale - PRESCALE_BITS'(1);
        end
    end

`ifdef PIO_LED_CTRL_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;

    // Free-running PWM counter and duty register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            duty    <= '1;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (wr_en && (address == ADDR_DUTY)) begin
                duty <= writedata[PWM_BITS-1:0];
            end
        end
    end

    // All-ones duty means fully on so the LED can reach 100%
    assign pwm_on = (duty == '1) || (pwm_cnt < duty);
`else
    assign pwm_on = 1'b1;
`endif

    // Per-bit gating: static bits follow DATA, blink bits also follow the phase
    always_comb begin
        out_next = data & (~mode | {WIDTH{blink_phase}}) & {WIDTH{pwm_on}};
    end

    // Registered LED drive
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= '0;
        end else begin
            out_port <= out_next;
        end
    end

    // Combinational, side-effect-free read mux, zero-extended
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata = 32'(data);
            ADDR_MODE:                       readdata = 32'(mode);
            ADDR_PERIOD:                     readdata = 32'(period);
`ifdef PIO_LED_CTRL_PWM_EN
            ADDR_DUTY:                       readdata = 32'(duty);
`endif
            default:                         readdata = '0;
        endcase
    end

endmodule
